// File: rtl/spi_master_xfer.sv
// SPI mode-0 master moving one byte per handshake; consecutive bytes share one
// chip-select window until a byte flagged tx_last completes.
`timescale 1ns/1ps
module spi_master_xfer #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       cs,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic       phase_q, phase_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       last_q, last_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ready_q, tx_ready_d;
  logic       busy_q, busy_d;
  logic       cs_q, cs_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       xfer_s;
  logic       div_done_s;

  assign xfer_s     = tx_valid & tx_ready_q;
  assign div_done_s = (div_q == 8'd0);

  // Next-state and datapath: phase_q splits each bit into its sck-high and
  // sck-low half-periods; bit 7 keeps sck high through both halves.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    tx_sh_d    = tx_sh_q;
    last_d     = last_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_d       = cs_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    if (div_done_s) begin
      div_d = 8'd0;
    end else begin
      div_d = div_q - 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        if (xfer_s) begin
          state_d = S_SETUP;
          cs_d    = 1'b0;
          tx_sh_d = tx_data;
          last_d  = tx_last;
          mosi_d  = tx_data[7];
          div_d   = DIV_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (div_done_s) begin
          state_d = S_SHIFT;
          div_d   = DIV_RELOAD;
          sck_d   = 1'b1;
          bit_d   = 3'd0;
          phase_d = 1'b0;
          rx_sh_d = {rx_sh_q[6:0], miso};
        end else begin
          state_d = S_SETUP;
        end
      end
      S_SHIFT: begin
        if (div_done_s) begin
          div_d = DIV_RELOAD;
          if (!phase_q) begin
            phase_d = 1'b1;
            if (bit_q != 3'd7) begin
              sck_d   = 1'b0;
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
              mosi_d  = tx_sh_q[6];
            end else begin
              sck_d = 1'b1;
            end
          end else if (bit_q == 3'd7) begin
            state_d    = last_q ? S_HOLD : S_WAIT;
            sck_d      = 1'b0;
            bit_d      = 3'd0;
            phase_d    = 1'b0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            phase_d = 1'b0;
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], miso};
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_WAIT: begin
        // Next byte starts straight at its first sck rise; no setup phase.
        if (xfer_s) begin
          state_d = S_SHIFT;
          tx_sh_d = tx_data;
          last_d  = tx_last;
          mosi_d  = tx_data[7];
          div_d   = DIV_RELOAD;
          sck_d   = 1'b1;
          bit_d   = 3'd0;
          phase_d = 1'b0;
          rx_sh_d = {rx_sh_q[6:0], miso};
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (div_done_s) begin
          state_d = S_GAP;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          div_d   = GAP_RELOAD;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_GAP: begin
        if (div_done_s) begin
          state_d = S_IDLE;
          div_d   = 8'd0;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        div_d   = 8'd0;
      end
    endcase

    tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= 8'd0;
      bit_q      <= 3'd0;
      phase_q    <= 1'b0;
      tx_sh_q    <= 8'd0;
      last_q     <= 1'b0;
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      tx_sh_q    <= tx_sh_d;
      last_q     <= last_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign cs       = cs_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;

endmodule
